// File: rtl/aes128_round_engine.sv
// Iterative AES-128 core running UNROLL round stages per clock (1, 2, 5 or 10).
// Define AES_ENGINE_DEC_EN to build the inverse datapath; otherwise encrypt-only.
module aes128_round_engine #(
  parameter int UNROLL = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  output logic                  ready_o,
  input  logic                  enc_or_dec_i,
  input  logic [127:0]          data_i,
  output logic [3:0]            key_idx_o,
  input  logic [128*UNROLL-1:0] key_i,
  output logic [127:0]          data_o,
  output logic                  valid_o,
  input  logic                  ack_i
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes128_round_engine: UNROLL must be 1, 2, 5 or 10");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] INIT  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] STEP     = 4'(UNROLL);
  localparam logic [3:0] ENC_LAST = 4'(11 - UNROLL);
  localparam logic [3:0] DEC_LAST = 4'(UNROLL - 1);
  localparam logic [31:0] MC      = 32'h02030101;

  logic [1:0]   fsm;
  logic [3:0]   ctr;
  logic [127:0] st;
  logic [127:0] nxt;
  logic [3:0]   stage_idx;
  logic         mode;
  logic         last_round;

  function automatic logic [3:0] bi(input int r, input int c);
    return 4'(15 - 4 * r - c);
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [15:0][7:0] a, o;
    a = s;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[bi(r, c)] = sbox(a[bi(r, (c + r) % 4)]);
    return o;
  endfunction

  // column transform with circulant coefficients m (m0 in the top byte)
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] m);
    logic [15:0][7:0] a, o;
    logic [3:0][7:0] mm;
    logic [7:0] acc;
    a = s;
    o = '0;
    mm = m;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(a[bi(j, c)], mm[2'(3 - ((j - r) & 3))]);
        o[bi(r, c)] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    t = sub_shift(s);
    if (!last) t = mix(t, MC);
    return t ^ k;
  endfunction

`ifdef AES_ENGINE_DEC_EN
  localparam logic [31:0] IMC = 32'h0e0b0d09;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [15:0][7:0] a, o;
    a = s;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[bi(r, c)] = inv_sbox(a[bi(r, (c + 4 - r) % 4)]);
    return o;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    t = inv_sub_shift(s) ^ k;
    if (!last) t = mix(t, IMC);
    return t;
  endfunction
`else
  logic unused_mode;
  assign unused_mode = enc_or_dec_i;
`endif

  always_comb begin
    nxt = st;
    stage_idx = '0;
    for (int k = 0; k < UNROLL; k++) begin
      stage_idx = mode ? ctr + 4'(k) : ctr - 4'(k);
`ifdef AES_ENGINE_DEC_EN
      if (mode) nxt = enc_round(nxt, key_i[128*k +: 128], stage_idx == 4'd10);
      else      nxt = dec_round(nxt, key_i[128*k +: 128], stage_idx == 4'd0);
`else
      nxt = enc_round(nxt, key_i[128*k +: 128], stage_idx == 4'd10);
`endif
    end
  end

  assign last_round = mode ? (ctr == ENC_LAST) : (ctr == DEC_LAST);
  assign ready_o = (fsm == IDLE);
  assign valid_o = (fsm == DONE);

  always_comb begin
    key_idx_o = 4'd0;
    unique case (fsm)
      IDLE:  key_idx_o = 4'd0;
      INIT:  key_idx_o = mode ? 4'd0 : 4'd10;
      ROUND: key_idx_o = ctr;
      DONE:  key_idx_o = 4'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fsm    <= IDLE;
      ctr    <= '0;
      st     <= '0;
      mode   <= 1'b1;
      data_o <= '0;
    end else begin
      unique case (fsm)
        IDLE: if (start_i) begin
          st  <= data_i;
`ifdef AES_ENGINE_DEC_EN
          mode <= enc_or_dec_i;
`else
          mode <= 1'b1;
`endif
          fsm <= INIT;
        end
        INIT: begin
          st  <= st ^ key_i[127:0];
          ctr <= mode ? 4'd1 : 4'd9;
          fsm <= ROUND;
        end
        ROUND: begin
          st <= nxt;
          if (last_round) begin
            data_o <= nxt;
            ctr    <= '0;
            fsm    <= DONE;
          end else begin
            ctr <= mode ? ctr + STEP : ctr - STEP;
          end
        end
        DONE: if (ack_i) fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_round_engine.sv
// Bench for aes128_round_engine: UNROLL 1/2/5/10 side by side, FIPS-197 and random
// blocks against a table-driven AES model; decrypt paths follow AES_ENGINE_DEC_EN.
module tb_aes128_round_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
  logic         mode;
  logic [127:0] din;
  logic         ack;
  bit           kdir;

  logic         rdy  [4];
  logic         vld  [4];
  logic [3:0]   kidx [4];
  logic [127:0] dout [4];

  logic [127:0] rk [0:10];
  logic [7:0]   sbox [256];

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [127:0] SROW [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    logic [128*U-1:0] key;

    // key store: slice k serves the k-th key after key_idx_o in round order
    always_comb begin
      key = '0;
      for (int k = 0; k < U; k++) begin
        if (kdir) begin
          if (int'(kidx[g]) + k <= 10) key[128*k +: 128] = rk[4'(int'(kidx[g]) + k)];
        end else if (int'(kidx[g]) >= k) begin
          key[128*k +: 128] = rk[4'(int'(kidx[g]) - k)];
        end
      end
    end

    aes128_round_engine #(.UNROLL(U)) u_dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .start_i      (start),
      .ready_o      (rdy[g]),
      .enc_or_dec_i (mode),
      .data_i       (din),
      .key_idx_o    (kidx[g]),
      .key_i        (key),
      .data_o       (dout[g]),
      .valid_o      (vld[g]),
      .ack_i        (ack)
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int ulat(input int g);
    return (g == 0) ? 12 : (g == 1) ? 7 : (g == 2) ? 4 : 3;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
  endfunction

  function automatic logic [7:0] byt(input logic [127:0] x, input int r, input int c);
    return x[127-8*(4*r+c) -: 8];
  endfunction

  // FIPS byte string (column-major) <-> row-major packing
  function automatic logic [127:0] tr(input logic [127:0] x);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*((i % 4) * 4 + i / 4) -: 8] = x[127-8*i -: 8];
    return o;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]] ^ rc, sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          rk[r][127-8*(4*j+c) -: 8] = w[4*r+c][31-8*j -: 8];
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = byt(pt, r, c) ^ byt(rk[0], r, c);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sbox[s[r][(c + r) % 4]];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
          t[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = t[r][c] ^ byt(rk[rnd], r, c);
    end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[127-8*(4*r+c) -: 8] = s[r][c];
    return o;
  endfunction

  task automatic run(input string tag, input logic [127:0] d, input logic enc,
                     input logic [127:0] exp_v, input int hold, input bit poke,
                     input bit ack_start);
    int lat [4];
    logic [43:0] seq, eseq;
    bit all;
`ifdef AES_ENGINE_DEC_EN
    kdir = enc;
`else
    kdir = 1'b1;
`endif
    for (int g = 0; g < 4; g++) lat[g] = 0;
    seq = '0;
    eseq = '0;
    for (int i = 0; i < 11; i++) eseq[4*(10-i) +: 4] = kdir ? 4'(i) : 4'(10 - i);
    @(negedge clk);
    check($sformatf("%s_ready", tag), 128'(rdy[0]), 128'd1);
    din = d;
    mode = enc;
    start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = poke && (n == 3);
      if (n <= 11) seq[4*(11-n) +: 4] = kidx[0];
      all = 1'b1;
      for (int g = 0; g < 4; g++) begin
        if (lat[g] == 0 && vld[g]) lat[g] = n;
        if (lat[g] == 0) all = 1'b0;
      end
      if (all) break;
    end
    start = 1'b0;
    check($sformatf("%s_keyseq", tag), 128'(seq), 128'(eseq));
    for (int g = 0; g < 4; g++) begin
      check($sformatf("%s_lat_g%0d", tag, g), 128'(lat[g]), 128'(ulat(g)));
      check($sformatf("%s_data_g%0d", tag, g), dout[g], exp_v);
    end
    for (int h = 0; h < hold; h++) begin
      start = poke;
      @(negedge clk);
    end
    if (hold > 0)
      for (int g = 0; g < 4; g++) begin
        check($sformatf("%s_held_valid_g%0d", tag, g), 128'(vld[g]), 128'd1);
        check($sformatf("%s_held_data_g%0d", tag, g), dout[g], exp_v);
      end
    start = ack_start;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    start = 1'b0;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("%s_idle_g%0d", tag, g), 128'({rdy[g], vld[g]}), 128'b10);
      check($sformatf("%s_kept_g%0d", tag, g), dout[g], exp_v);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    logic [127:0] p, c;
    int seen;
    for (int i = 0; i < 256; i++) sbox[i] = SROW[i / 16][127-8*(i % 16) -: 8];
    rst_n = 1'b0;
    start = 1'b0;
    ack = 1'b0;
    mode = 1'b1;
    din = '0;
    kdir = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rst_ctl_g%0d", g), 128'({rdy[g], vld[g], kidx[g]}), 128'h20);
      check($sformatf("rst_data_g%0d", g), dout[g], 128'd0);
    end
    rst_n = 1'b1;

    expand(C1_KEY);
    run("c1_enc", tr(C1_PT), 1'b1, tr(C1_CT), 0, 1'b0, 1'b0);
    run("c1_hs", tr(C1_PT), 1'b1, tr(C1_CT), 5, 1'b1, 1'b1);
`ifdef AES_ENGINE_DEC_EN
    run("c1_dec", tr(C1_CT), 1'b0, tr(C1_PT), 1, 1'b0, 1'b0);
`else
    run("c1_mode0", tr(C1_PT), 1'b0, tr(C1_CT), 1, 1'b0, 1'b0);
`endif

    expand(B_KEY);
    run("appb", tr(B_PT), 1'b1, tr(B_CT), 0, 1'b0, 1'b0);

    // abort a block with a one-cycle reset in the middle of its rounds
    expand(C1_KEY);
    kdir = 1'b1;
    @(negedge clk);
    din = tr(C1_PT);
    mode = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 4; g++)
      check($sformatf("midrst_ctl_g%0d", g), 128'({rdy[g], vld[g], kidx[g]}), 128'h20);
    seen = 0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) if (vld[g]) seen++;
    end
    check("midrst_no_valid", 128'(seen), 128'd0);
    run("c1_after_rst", tr(C1_PT), 1'b1, tr(C1_CT), 0, 1'b0, 1'b0);

    for (int it = 0; it < 6; it++) begin
      expand({$urandom, $urandom, $urandom, $urandom});
      p = {$urandom, $urandom, $urandom, $urandom};
      c = model_enc(p);
      run($sformatf("rnd%0d_enc", it), p, 1'b1, c, $urandom_range(0, 3), 1'b0, 1'b0);
`ifdef AES_ENGINE_DEC_EN
      run($sformatf("rnd%0d_dec", it), c, 1'b0, p, $urandom_range(0, 3), 1'b0, 1'b0);
`else
      run($sformatf("rnd%0d_m0", it), p, 1'b0, c, $urandom_range(0, 3), 1'b0, 1'b0);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
